// File: rtl/clocks_pkg.sv
// rtl/clocks_pkg.sv - shared constants, channel state type and ratio clamp for the divider bank
package clocks_pkg;

    localparam int MIN_DIV     = 2;
    localparam int DEFAULT_DIV = 4;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Ratios below MIN_DIV cannot produce a square wave, so they are raised to it.
    function automatic logic [31:0] clamp_div(input logic [31:0] ratio);
        return (ratio < 32'(MIN_DIV)) ? 32'(MIN_DIV) : ratio;
    endfunction

endpackage

// File: rtl/clocks_div_ch.sv
// rtl/clocks_div_ch.sv - one glitch-free divider channel: counter, pending ratio, run FSM, output regs
module clocks_div_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = clocks_pkg::DEFAULT_DIV
) (
    input  logic             clk_10M_ref,
    input  logic             reset,
    input  logic             ch_en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             load,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);
    import clocks_pkg::*;

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] r_q, r_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] load_r;
    logic             last;
    logic             start;

    assign load_r = DIV_W'(clamp_div(32'(div_ratio)));
    assign last   = (cnt_q == r_q - DIV_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        start     = 1'b0;
        case (state_q)
            CH_IDLE: start = ch_en;
            CH_RUN: begin
                clk_out_d = (cnt_q < (r_q >> 1));
                tick_d    = (cnt_q == '0);
                // sync wins over terminal count, so a disabled channel under sync runs one more period
                start     = sync || (last && ch_en);
                if (!start) begin
                    if (last) begin
                        state_d = CH_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
            end
            default: state_d = CH_IDLE;
        endcase
        // A new period begins: adopt the freshest ratio, preferring a same-cycle load.
        if (start) begin
            state_d  = CH_RUN;
            cnt_d    = '0;
            pend_v_d = 1'b0;
            if (load) begin
                r_d = load_r;
            end else if (pend_v_q) begin
                r_d = pend_q;
            end
        end else if (load) begin
            pend_d   = load_r;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk_10M_ref) begin
        if (reset) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            r_q       <= DIV_W'(DEFAULT_DIV);
            pend_q    <= DIV_W'(DEFAULT_DIV);
            pend_v_q  <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign active  = (state_q == CH_RUN);

endmodule

// File: rtl/clocks_div_bank.sv
// rtl/clocks_div_bank.sv - N_CH programmable clock dividers off the 10 MHz reference with shared load/sync
module clocks_div_bank #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = clocks_pkg::DEFAULT_DIV
) (
    input  logic                  clk_10M_ref,
    input  logic                  reset,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH*DIV_W-1:0] div_ratio,
    input  logic                  load,
    input  logic                  sync,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       active
);
    import clocks_pkg::*;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clocks_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_10M_ref (clk_10M_ref),
            .reset       (reset),
            .ch_en       (ch_en[i]),
            .div_ratio   (div_ratio[i*DIV_W +: DIV_W]),
            .load        (load),
            .sync        (sync),
            .clk_out     (clk_out[i]),
            .tick        (tick[i]),
            .active      (active[i])
        );
    end

endmodule

// File: tb/tb_clocks_div_bank.sv
// tb/tb_clocks_div_bank.sv - self-checking bench for clocks_div_bank
module tb_clocks_div_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ch_en = '0;
    logic [63:0] div_ratio = '0;
    logic        load = 1'b0;
    logic        sync = 1'b0;
    logic [3:0]  clk_out, tick, active;

    int checks = 0;
    int errors = 0;

    // Reference: position within the current period, ratio in force, pending ratio (-1 = none).
    bit m_run  [4];
    int m_pos  [4];
    int m_ratio[4];
    int m_pend [4];
    bit m_clk  [4];
    bit m_tick [4];

    clocks_div_bank #(.N_CH(4), .DIV_W(16), .DEFAULT_DIV(4)) dut (
        .clk_10M_ref (clk),
        .reset       (reset),
        .ch_en       (ch_en),
        .div_ratio   (div_ratio),
        .load        (load),
        .sync        (sync),
        .clk_out     (clk_out),
        .tick        (tick),
        .active      (active)
    );

    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic model_step(input logic rst, input logic [3:0] en, input logic ld,
                              input logic sy, input logic [63:0] dr);
        int  nr;
        bit  begins;
        for (int i = 0; i < 4; i++) begin
            nr = int'(dr[i*16 +: 16]);
            if (nr < 2) nr = 2;
            if (rst) begin
                m_run[i] = 0; m_pos[i] = 0; m_ratio[i] = 4; m_pend[i] = -1;
                m_clk[i] = 0; m_tick[i] = 0;
            end else begin
                m_clk[i]  = m_run[i] && (m_pos[i] < m_ratio[i] / 2);
                m_tick[i] = m_run[i] && (m_pos[i] == 0);
                if (m_run[i]) begins = sy || (m_pos[i] == m_ratio[i] - 1 && en[i]);
                else          begins = en[i];
                if (begins) begin
                    m_run[i]   = 1;
                    m_pos[i]   = 0;
                    m_ratio[i] = ld ? nr : ((m_pend[i] >= 0) ? m_pend[i] : m_ratio[i]);
                    m_pend[i]  = -1;
                end else begin
                    if (m_run[i]) begin
                        if (m_pos[i] == m_ratio[i] - 1) begin
                            m_run[i] = 0;
                            m_pos[i] = 0;
                        end else begin
                            m_pos[i] = m_pos[i] + 1;
                        end
                    end
                    if (ld) m_pend[i] = nr;
                end
            end
        end
    endtask

    task automatic cycle();
        logic        r, l, s;
        logic [3:0]  e;
        logic [63:0] d;
        r = reset; e = ch_en; l = load; s = sync; d = div_ratio;
        @(posedge clk);
        #1;
        model_step(r, e, l, s, d);
    endtask

    task automatic do_reset();
        reset = 1'b1; ch_en = '0; load = 1'b0; sync = 1'b0; div_ratio = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ch_en = 4'hF; load = 1'b1; sync = 1'b1; div_ratio = {4{16'd9}};
        cycle();
        cycle();
        checks++; if (clk_out !== 4'h0) begin errors++; $display("FAIL reset_clk_out got=%b exp=0000", clk_out); end
        checks++; if (tick !== 4'h0) begin errors++; $display("FAIL reset_tick got=%b exp=0000", tick); end
        checks++; if (active !== 4'h0) begin errors++; $display("FAIL reset_active got=%b exp=0000", active); end
        reset = 1'b0; ch_en = 4'h1; load = 1'b0; sync = 1'b0;
        cycle();
        // ratio loaded during reset must have been ignored: default 4 applies
        for (int j = 0; j < 8; j++) begin
            cycle();
            checks++;
            if (clk_out[0] !== ((j % 4) < 2)) begin
                errors++; $display("FAIL reset_ignores_load j=%0d got=%b exp=%b", j, clk_out[0], (j % 4) < 2);
            end
        end
    endtask

    task automatic test_div4();
        do_reset();
        ch_en = 4'b0001;
        cycle();
        checks++; if (active !== 4'b0001) begin errors++; $display("FAIL div4_start_active got=%b exp=0001", active); end
        checks++; if (clk_out !== 4'b0000) begin errors++; $display("FAIL div4_start_clk got=%b exp=0000", clk_out); end
        for (int j = 0; j < 12; j++) begin
            cycle();
            checks++;
            if (clk_out[0] !== ((j % 4) < 2)) begin
                errors++; $display("FAIL div4_clk j=%0d got=%b exp=%b", j, clk_out[0], (j % 4) < 2);
            end
            checks++;
            if (tick[0] !== ((j % 4) == 0)) begin
                errors++; $display("FAIL div4_tick j=%0d got=%b exp=%b", j, tick[0], (j % 4) == 0);
            end
        end
    endtask

    task automatic test_odd_and_clamp();
        int c, half;
        do_reset();
        div_ratio[31:16] = 16'd5; load = 1'b1;
        cycle();
        load = 1'b0; ch_en = 4'b0010;
        cycle();
        for (int j = 0; j < 22; j++) begin
            load = (j == 10);
            div_ratio[31:16] = (j >= 10) ? 16'd0 : 16'd5;
            cycle();
            if (j < 15) begin c = j % 5; half = 2; end
            else        begin c = (j - 15) % 2; half = 1; end
            checks++;
            if (clk_out[1] !== (c < half)) begin
                errors++; $display("FAIL odd_clamp_clk j=%0d got=%b exp=%b", j, clk_out[1], c < half);
            end
            checks++;
            if (tick[1] !== (c == 0)) begin
                errors++; $display("FAIL odd_clamp_tick j=%0d got=%b exp=%b", j, tick[1], c == 0);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_load_mid_and_terminal();
        int c, half;
        do_reset();
        ch_en = 4'b0001;
        cycle();
        for (int j = 0; j < 30; j++) begin
            load = (j == 2) || (j == 23);
            div_ratio[15:0] = (j <= 2) ? 16'd10 : 16'd3;
            cycle();
            if (j < 4)       begin c = j % 4;        half = 2; end
            else if (j < 24) begin c = (j - 4) % 10; half = 5; end
            else             begin c = (j - 24) % 3; half = 1; end
            checks++;
            if (clk_out[0] !== (c < half)) begin
                errors++; $display("FAIL load_mid_clk j=%0d got=%b exp=%b", j, clk_out[0], c < half);
            end
            checks++;
            if (tick[0] !== (c == 0)) begin
                errors++; $display("FAIL load_mid_tick j=%0d got=%b exp=%b", j, tick[0], c == 0);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_graceful_disable();
        do_reset();
        div_ratio[47:32] = 16'd8; load = 1'b1;
        cycle();
        load = 1'b0; ch_en = 4'b0100;
        cycle();
        for (int j = 0; j < 12; j++) begin
            ch_en[2] = (j < 1);
            cycle();
            checks++;
            if (active[2] !== (j < 7)) begin
                errors++; $display("FAIL disable_active j=%0d got=%b exp=%b", j, active[2], j < 7);
            end
            checks++;
            if (clk_out[2] !== (j < 4)) begin
                errors++; $display("FAIL disable_clk j=%0d got=%b exp=%b", j, clk_out[2], j < 4);
            end
        end
    endtask

    task automatic test_sync();
        int         rr[4];
        logic [3:0] e_tick, e_clk;
        rr[0] = 4; rr[1] = 6; rr[2] = 8; rr[3] = 10;
        do_reset();
        div_ratio = {16'd10, 16'd8, 16'd6, 16'd4}; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ch_en = {k >= 5, k >= 3, k >= 1, 1'b1};
            cycle();
        end
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        for (int j = 0; j < 21; j++) begin
            cycle();
            for (int i = 0; i < 4; i++) begin
                e_tick[i] = (j % rr[i]) == 0;
                e_clk[i]  = (j % rr[i]) < rr[i] / 2;
            end
            checks++;
            if (tick !== e_tick) begin
                errors++; $display("FAIL sync_tick j=%0d got=%b exp=%b", j, tick, e_tick);
            end
            checks++;
            if (clk_out !== e_clk) begin
                errors++; $display("FAIL sync_clk j=%0d got=%b exp=%b", j, clk_out, e_clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ch_en = 4'b0001;
        cycle();
        cycle();
        cycle();
        div_ratio[15:0] = 16'd9; load = 1'b1;
        cycle();
        load = 1'b0; reset = 1'b1;
        cycle();
        checks++; if (clk_out !== 4'h0) begin errors++; $display("FAIL reset_mid_clk got=%b exp=0000", clk_out); end
        checks++; if (tick !== 4'h0) begin errors++; $display("FAIL reset_mid_tick got=%b exp=0000", tick); end
        checks++; if (active !== 4'h0) begin errors++; $display("FAIL reset_mid_active got=%b exp=0000", active); end
        reset = 1'b0;
        cycle();
        for (int j = 0; j < 12; j++) begin
            cycle();
            checks++;
            if (clk_out[0] !== ((j % 4) < 2)) begin
                errors++; $display("FAIL reset_mid_rerun j=%0d got=%b exp=%b", j, clk_out[0], (j % 4) < 2);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] e_clk, e_tick, e_act;
        do_reset();
        ch_en = 4'($urandom());
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 11) == 0) ch_en[$urandom_range(0, 3)] = ~ch_en[$urandom_range(0, 3)];
            load = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 4; i++) div_ratio[i*16 +: 16] = 16'($urandom_range(0, 12));
            sync  = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) == 0);
            cycle();
            for (int i = 0; i < 4; i++) begin
                e_clk[i] = m_clk[i]; e_tick[i] = m_tick[i]; e_act[i] = m_run[i];
            end
            checks++;
            if (clk_out !== e_clk) begin
                errors++; $display("FAIL rand_clk n=%0d got=%b exp=%b", n, clk_out, e_clk);
            end
            checks++;
            if (tick !== e_tick) begin
                errors++; $display("FAIL rand_tick n=%0d got=%b exp=%b", n, tick, e_tick);
            end
            checks++;
            if (active !== e_act) begin
                errors++; $display("FAIL rand_active n=%0d got=%b exp=%b", n, active, e_act);
            end
        end
        reset = 1'b0; load = 1'b0; sync = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_ratio[i] = 4; m_pend[i] = -1;
            m_clk[i] = 0; m_tick[i] = 0;
        end
        test_reset();
        test_div4();
        test_odd_and_clamp();
        test_load_mid_and_terminal();
        test_graceful_disable();
        test_sync();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
